counting_seq: RTL

Parametrised ordered-run sequence detector. It is the successor to the fixed 2-bit "1…2…3, then hold 1" counting state machine. It watches a stream of WIDTH-bit symbols and detects a programmable ordered pattern of STAGES symbols, where each symbol may repeat any number of times (a run). It raises a sticky flag, a one-cycle hit pulse and a saturating match count. It sits directly on the symbol stream in the exercise designs and feeds status logic.

---
 rtl/counting_pkg.sv | 34 +++
 rtl/counting_stage_sel.sv | 38 +++
 rtl/counting_seq.sv | 93 +++++++++
 3 files changed

// File: rtl/counting_pkg.sv
// Shared types and helpers for the ordered-run sequence detector.
// Pattern symbols are extracted from a zero-extended flat vector so one helper serves any size.
package counting_pkg;

  localparam int unsigned MaxStages = 16;
  localparam int unsigned MaxWidth  = 16;
  localparam int unsigned ST_IDLE   = 0;

  typedef logic [MaxStages*MaxWidth-1:0] pattern_flat_t;

  // Which priority rule fired on a sampled symbol.
  typedef enum logic [2:0] {
    TrHold,
    TrAdvance,
    TrStay,
    TrRestart,
    TrDrop
  } trans_e;

  function automatic int unsigned state_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

  function automatic logic [MaxWidth-1:0] stage_sym(input pattern_flat_t pat,
                                                    input int unsigned   idx,
                                                    input int unsigned   width);
    pattern_flat_t       shifted;
    logic [MaxWidth-1:0] mask;
    shifted = pat >> (idx * width);
    mask    = (MaxWidth'(1) << width) - MaxWidth'(1);
    return shifted[MaxWidth-1:0] & mask;
  endfunction

endpackage

// File: rtl/counting_stage_sel.sv
// Combinational lookup of the pattern symbols relevant to the current state:
// P[s] (advance target), P[s-1] (run being held) and P[0] (restart target).
module counting_stage_sel
  import counting_pkg::*;
#(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned STATE_W = state_width(STAGES)
) (
  input  logic [STATE_W-1:0]      state,
  input  logic [STAGES*WIDTH-1:0] pattern,
  output logic [WIDTH-1:0]        sym_cur,
  output logic [WIDTH-1:0]        sym_prev,
  output logic [WIDTH-1:0]        sym_first
);

  pattern_flat_t    pat_ext;
  logic [WIDTH-1:0] syms [STAGES];

  assign pat_ext = pattern_flat_t'(pattern);

  for (genvar i = 0; i < STAGES; i++) begin : g_sym
    assign syms[i] = WIDTH'(stage_sym(pat_ext, i, WIDTH));
  end

  // Out-of-range lookups (P[STAGES], P[-1]) return 0; the FSM never uses them.
  always_comb begin
    sym_cur  = '0;
    sym_prev = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (state == STATE_W'(i))     sym_cur  = syms[i];
      if (state == STATE_W'(i + 1)) sym_prev = syms[i];
    end
  end

  assign sym_first = syms[0];

endmodule

// File: rtl/counting_seq.sv
// Ordered-run sequence detector: matches STAGES programmable symbols, each repeatable,
// and reports a sticky flag, a one-cycle hit pulse and a saturating match count.
module counting_seq
  import counting_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        num,
  input  logic [STAGES*WIDTH-1:0] pattern,
  output logic                    ans,
  output logic                    hit,
  output logic [CNT_W-1:0]        match_cnt
);

  localparam int unsigned        STATE_W = state_width(STAGES);
  localparam logic [STATE_W-1:0] StIdle  = STATE_W'(ST_IDLE);
  localparam logic [STATE_W-1:0] StDone  = STATE_W'(STAGES);
  localparam logic [STATE_W-1:0] StLast  = STATE_W'(STAGES - 1);
  localparam logic [CNT_W-1:0]   CntMax  = {CNT_W{1'b1}};

  logic [STATE_W-1:0] state_q, state_d;
  logic               ans_q, hit_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   sym_cur, sym_prev, sym_first;
  trans_e             trans;
  logic               complete;

  counting_stage_sel #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .STATE_W(STATE_W)
  ) u_stage_sel (
    .state    (state_q),
    .pattern  (pattern),
    .sym_cur  (sym_cur),
    .sym_prev (sym_prev),
    .sym_first(sym_first)
  );

  // Advance beats stay, so adjacent equal stages step forward on each repeat.
  always_comb begin
    trans   = TrHold;
    state_d = state_q;
    if (in_valid) begin
      if (state_q != StDone && num == sym_cur) begin
        trans   = TrAdvance;
        state_d = state_q + STATE_W'(1);
      end else if (state_q != StIdle && num == sym_prev) begin
        trans   = TrStay;
      end else if (num == sym_first) begin
        trans   = TrRestart;
        state_d = STATE_W'(1);
      end else begin
        trans   = TrDrop;
        state_d = StIdle;
      end
    end
  end

  assign complete = (trans == TrAdvance) && (state_q == StLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ans_q   <= 1'b0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (clr) begin
      state_q <= StIdle;
      ans_q   <= 1'b0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= complete;
      if (complete) begin
        ans_q <= 1'b1;
        if (cnt_q != CntMax) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign ans       = ans_q;
  assign hit       = hit_q;
  assign match_cnt = cnt_q;

endmodule
